decode_cycle: RTL and testbench

Instruction-decode stage of the 5-stage pipeline. It sits between the IF/ID register of the fetch stage and the execute stage. It holds the 32x32 register file, decodes the fetched word, and resolves jumps and branches in decode, driving PC_Src, jumpAddress and branchAddress back to fetch. It also detects load-use and branch-operand hazards, squashes the wrong-path instruction after a redirect, and registers all execute-stage controls and operands into the ID/EX pipeline register.

---
 rtl/decode_cycle.sv | 256 +++++++++++++++++++++++++
 tb/tb_decode_cycle.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_cycle.sv
// Instruction-decode stage: register file, decoder, early jump/branch resolution,
// load-use and branch-operand stalls, wrong-path squash and the ID/EX register.
module decode_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instruction,
  input  logic [31:0] PC_Next,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [1:0]  PC_Src,
  output logic [31:0] jumpAddress,
  output logic [31:0] branchAddress,
  output logic        stall,
  output logic        ex_valid,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_rd,
  output logic [3:0]  ex_alu_op,
  output logic        ex_alu_src,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        illegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;

  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd;

  assign opcode = Instruction[31:26];
  assign rs     = Instruction[25:21];
  assign rt     = Instruction[20:16];
  assign rd     = Instruction[15:11];
  assign funct  = Instruction[5:0];

  logic [31:0] regs_reg [32];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs_reg[i] <= '0;
    end else if (wb_we && (wb_rd != 5'd0)) begin
      regs_reg[wb_rd] <= wb_data;
    end
  end

  // Two read ports with write-through so writeback reaches decode in the same cycle.
  logic [4:0]  rd_addr [2];
  logic [31:0] rd_val  [2];
  logic [31:0] rs_val, rt_val;

  assign rd_addr[0] = rs;
  assign rd_addr[1] = rt;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_read_port
      assign rd_val[gi] = (rd_addr[gi] == 5'd0) ? 32'd0 :
                          (wb_we && (wb_rd == rd_addr[gi])) ? wb_data :
                          regs_reg[rd_addr[gi]];
    end
  endgenerate

  assign rs_val = rd_val[0];
  assign rt_val = rd_val[1];

  logic        dec_valid, dec_illegal, dec_alu_src, dec_reg_write, dec_mem_read, dec_mem_write;
  logic        dec_use_rs, dec_use_rt, dec_branch, dec_bne, dec_jump;
  logic [3:0]  dec_alu_op;
  logic [4:0]  dec_rd;
  logic [31:0] dec_imm;

  always_comb begin
    dec_valid     = 1'b0;
    dec_illegal   = 1'b0;
    dec_alu_src   = 1'b0;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_use_rs    = 1'b0;
    dec_use_rt    = 1'b0;
    dec_branch    = 1'b0;
    dec_bne       = 1'b0;
    dec_jump      = 1'b0;
    dec_alu_op    = ALU_ADD;
    dec_rd        = 5'd0;
    dec_imm       = (opcode == OP_ANDI) ? {16'd0, Instruction[15:0]}
                                        : {{16{Instruction[15]}}, Instruction[15:0]};
    if (Instruction != 32'd0) begin
      case (opcode)
        OP_RTYPE: begin
          dec_valid     = 1'b1;
          dec_reg_write = 1'b1;
          dec_use_rs    = 1'b1;
          dec_use_rt    = 1'b1;
          dec_rd        = rd;
          case (funct)
            F_ADD:   dec_alu_op = ALU_ADD;
            F_SUB:   dec_alu_op = ALU_SUB;
            F_AND:   dec_alu_op = ALU_AND;
            F_OR:    dec_alu_op = ALU_OR;
            F_SLT:   dec_alu_op = ALU_SLT;
            default: dec_valid  = 1'b0;
          endcase
        end
        OP_ADDI, OP_ANDI: begin
          dec_valid     = 1'b1;
          dec_alu_src   = 1'b1;
          dec_reg_write = 1'b1;
          dec_use_rs    = 1'b1;
          dec_rd        = rt;
          dec_alu_op    = (opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
        end
        OP_LW: begin
          dec_valid     = 1'b1;
          dec_alu_src   = 1'b1;
          dec_reg_write = 1'b1;
          dec_mem_read  = 1'b1;
          dec_use_rs    = 1'b1;
          dec_rd        = rt;
        end
        OP_SW: begin
          dec_valid     = 1'b1;
          dec_alu_src   = 1'b1;
          dec_mem_write = 1'b1;
          dec_use_rs    = 1'b1;
          dec_use_rt    = 1'b1;
          dec_rd        = rt;
        end
        OP_BEQ, OP_BNE: begin
          dec_valid  = 1'b1;
          dec_branch = 1'b1;
          dec_bne    = (opcode == OP_BNE);
          dec_use_rs = 1'b1;
          dec_use_rt = 1'b1;
          dec_alu_op = ALU_SUB;
          dec_rd     = rt;
        end
        OP_J: begin
          dec_valid = 1'b1;
          dec_jump  = 1'b1;
        end
        default: ;
      endcase
      dec_illegal = !dec_valid;
    end
  end

  logic       squash_reg;
  logic [4:0] mem_rd_reg;
  logic       mem_reg_write_reg;
  logic       live, active, load_use, branch_hazard, issue;

  // A held reset or a set squash flag turns the incoming word into a bubble.
  assign live   = rst && !squash_reg;
  assign active = live && dec_valid;

  assign load_use = active && ex_mem_read && (ex_rd != 5'd0) &&
                    ((dec_use_rs && (ex_rd == rs)) || (dec_use_rt && (ex_rd == rt)));

  assign branch_hazard = active && dec_branch &&
                         ((ex_reg_write && (ex_rd != 5'd0) && ((ex_rd == rs) || (ex_rd == rt))) ||
                          (mem_reg_write_reg && (mem_rd_reg != 5'd0) &&
                           ((mem_rd_reg == rs) || (mem_rd_reg == rt))));

  assign stall = load_use || branch_hazard;
  assign issue = active && !stall;

  always_comb begin
    PC_Src = 2'b00;
    if (issue && dec_jump) begin
      PC_Src = 2'b01;
    end else if (issue && dec_branch && ((rs_val == rt_val) != dec_bne)) begin
      PC_Src = 2'b10;
    end
  end

  assign jumpAddress   = {PC_Next[31:28], Instruction[25:0], 2'b00};
  assign branchAddress = PC_Next + {{14{Instruction[15]}}, Instruction[15:0], 2'b00};

  always_ff @(posedge clk) begin
    if (!rst) begin
      squash_reg        <= 1'b0;
      illegal           <= 1'b0;
      mem_rd_reg        <= 5'd0;
      mem_reg_write_reg <= 1'b0;
      ex_valid          <= 1'b0;
      ex_rs_data        <= 32'd0;
      ex_rt_data        <= 32'd0;
      ex_imm            <= 32'd0;
      ex_rs             <= 5'd0;
      ex_rt             <= 5'd0;
      ex_rd             <= 5'd0;
      ex_alu_op         <= 4'd0;
      ex_alu_src        <= 1'b0;
      ex_reg_write      <= 1'b0;
      ex_mem_read       <= 1'b0;
      ex_mem_write      <= 1'b0;
    end else begin
      squash_reg        <= (PC_Src != 2'b00);
      illegal           <= !squash_reg && dec_illegal;
      mem_rd_reg        <= ex_rd;
      mem_reg_write_reg <= ex_reg_write;
      ex_valid          <= issue;
      if (issue) begin
        ex_rs_data   <= rs_val;
        ex_rt_data   <= rt_val;
        ex_imm       <= dec_imm;
        ex_rs        <= rs;
        ex_rt        <= rt;
        ex_rd        <= dec_rd;
        ex_alu_op    <= dec_alu_op;
        ex_alu_src   <= dec_alu_src;
        ex_reg_write <= dec_reg_write;
        ex_mem_read  <= dec_mem_read;
        ex_mem_write <= dec_mem_write;
      end else begin
        ex_rs_data   <= 32'd0;
        ex_rt_data   <= 32'd0;
        ex_imm       <= 32'd0;
        ex_rs        <= 5'd0;
        ex_rt        <= 5'd0;
        ex_rd        <= 5'd0;
        ex_alu_op    <= 4'd0;
        ex_alu_src   <= 1'b0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
        ex_mem_write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_cycle.sv
// Bench for decode_cycle: directed vector table for the multi-cycle corner cases,
// then random instruction streams, all checked against an instruction-level model.
module tb_decode_cycle;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] Instruction, PC_Next;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  PC_Src;
  logic [31:0] jumpAddress, branchAddress;
  logic        stall, ex_valid;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, illegal;

  decode_cycle dut (
    .clk(clk), .rst(rst), .Instruction(Instruction), .PC_Next(PC_Next),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .PC_Src(PC_Src), .jumpAddress(jumpAddress), .branchAddress(branchAddress),
    .stall(stall), .ex_valid(ex_valid), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
    .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .illegal(illegal)
  );

  // Semantic meaning of one instruction word.
  typedef struct packed {
    logic ok, bad;
    logic [3:0] op;
    logic src, rw, mr, mw;
    logic [4:0] dst;
    logic [31:0] imm;
    logic use_s, use_t, br, ne, jmp;
  } dec_t;

  typedef struct packed {
    logic v;
    logic [31:0] sd, td, imm;
    logic [4:0] rs, rt, rd;
    logic [3:0] op;
    logic src, rw, mr, mw;
  } ex_t;

  typedef struct packed {
    logic r;
    logic [31:0] ins, pcn;
    logic we;
    logic [4:0] wrd;
    logic [31:0] wd;
    logic [1:0] ps;
    logic stl;
    logic [1:0] ak;
    logic [31:0] addr;
    logic v;
    logic [4:0] rs;
    logic [31:0] rsd;
    logic ill;
  } row_t;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_regs [32];
  ex_t         m_ex;
  logic [4:0]  m_sh_rd;
  logic        m_sh_rw, m_sq, m_ill;

  logic [1:0]  a_pcsrc;
  logic        a_stall;
  logic [31:0] a_jaddr, a_baddr;

  row_t tbl [23];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic dec_t dec(input logic [31:0] w);
    dec_t d;
    d = '0;
    d.imm = (w[31:26] == 6'h0C) ? {16'd0, w[15:0]} : 32'($signed(w[15:0]));
    case (w[31:26])
      6'h00: begin
        d.ok = 1'b1; d.rw = 1'b1; d.use_s = 1'b1; d.use_t = 1'b1; d.dst = w[15:11];
        case (w[5:0])
          6'h20: d.op = 4'd0;
          6'h22: d.op = 4'd1;
          6'h24: d.op = 4'd2;
          6'h25: d.op = 4'd3;
          6'h2A: d.op = 4'd4;
          default: d.ok = 1'b0;
        endcase
      end
      6'h08: begin d.ok = 1'b1; d.src = 1'b1; d.rw = 1'b1; d.use_s = 1'b1; d.dst = w[20:16]; end
      6'h0C: begin d.ok = 1'b1; d.src = 1'b1; d.rw = 1'b1; d.use_s = 1'b1; d.dst = w[20:16]; d.op = 4'd2; end
      6'h23: begin d.ok = 1'b1; d.src = 1'b1; d.rw = 1'b1; d.mr = 1'b1; d.use_s = 1'b1; d.dst = w[20:16]; end
      6'h2B: begin d.ok = 1'b1; d.src = 1'b1; d.mw = 1'b1; d.use_s = 1'b1; d.use_t = 1'b1; d.dst = w[20:16]; end
      6'h04: begin d.ok = 1'b1; d.br = 1'b1; d.use_s = 1'b1; d.use_t = 1'b1; d.op = 4'd1; d.dst = w[20:16]; end
      6'h05: begin d.ok = 1'b1; d.br = 1'b1; d.ne = 1'b1; d.use_s = 1'b1; d.use_t = 1'b1; d.op = 4'd1; d.dst = w[20:16]; end
      6'h02: begin d.ok = 1'b1; d.jmp = 1'b1; end
      default: ;
    endcase
    if (w == 32'd0 || !d.ok) begin
      d = '0;
      d.bad = (w != 32'd0);
    end
    return d;
  endfunction

  function automatic logic [31:0] rdm(input logic [4:0] a, input logic we, input logic [4:0] wa,
                                      input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (we && wa == a) return wd;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  s  = 5'($urandom_range(0, 7));
    logic [4:0]  t  = 5'($urandom_range(0, 7));
    logic [4:0]  d  = 5'($urandom_range(0, 7));
    logic [15:0] im = 16'($urandom);
    logic [5:0]  fn;
    case ($urandom_range(0, 4))
      0: fn = 6'h20;
      1: fn = 6'h22;
      2: fn = 6'h24;
      3: fn = 6'h25;
      default: fn = 6'h2A;
    endcase
    case ($urandom_range(0, 11))
      0, 1:    return {6'h00, s, t, d, 5'd0, fn};
      2:       return {6'h08, s, t, im};
      3:       return {6'h0C, s, t, im};
      4, 5:    return {6'h23, s, t, im};
      6:       return {6'h2B, s, t, im};
      7:       return {6'h04, s, t, im};
      8:       return {6'h05, s, t, im};
      9:       return {6'h02, 26'($urandom)};
      10:      return 32'd0;
      default: return ($urandom_range(0, 1) == 0) ? {6'h3F, 26'($urandom)} : {6'h00, s, t, d, 5'd0, 6'h01};
    endcase
  endfunction

  // One cycle: drive at posedge+1, check combinational outputs mid-cycle, advance the model, check ID/EX.
  task automatic step(input logic r, input logic [31:0] ins, input logic [31:0] pcn, input logic we,
                      input logic [4:0] wrd, input logic [31:0] wd, output logic stl);
    dec_t d;
    ex_t nx;
    logic [4:0] s, t;
    logic [31:0] sv, tv, ej, eb;
    logic live, hz, go;
    logic [1:0] ps;
    rst = r; Instruction = ins; PC_Next = pcn; wb_we = we; wb_rd = wrd; wb_data = wd;
    #4;
    d = dec(ins);
    s = ins[25:21];
    t = ins[20:16];
    sv = rdm(s, we, wrd, wd);
    tv = rdm(t, we, wrd, wd);
    live = r && !m_sq && d.ok;
    hz = live && ((m_ex.mr && m_ex.rd != 0 && ((d.use_s && m_ex.rd == s) || (d.use_t && m_ex.rd == t))) ||
                  (d.br && ((m_ex.rw && m_ex.rd != 0 && (m_ex.rd == s || m_ex.rd == t)) ||
                            (m_sh_rw && m_sh_rd != 0 && (m_sh_rd == s || m_sh_rd == t)))));
    go = live && !hz;
    ps = !go ? 2'd0 : d.jmp ? 2'd1 : (d.br && ((sv == tv) != d.ne)) ? 2'd2 : 2'd0;
    ej = {pcn[31:28], ins[25:0], 2'b00};
    eb = pcn + 32'(4 * $signed(ins[15:0]));
    a_pcsrc = PC_Src; a_stall = stall; a_jaddr = jumpAddress; a_baddr = branchAddress;
    chk("pc_src", 128'(a_pcsrc), 128'(ps));
    chk("stall", 128'(a_stall), 128'(hz));
    chk("jump_addr", 128'(a_jaddr), 128'(ej));
    chk("branch_addr", 128'(a_baddr), 128'(eb));
    stl = hz;
    nx = go ? {1'b1, sv, tv, d.imm, s, t, d.dst, d.op, d.src, d.rw, d.mr, d.mw} : '0;
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_ex = '0; m_sh_rd = 5'd0; m_sh_rw = 1'b0; m_sq = 1'b0; m_ill = 1'b0;
    end else begin
      if (we && wrd != 0) m_regs[wrd] = wd;
      m_sh_rd = m_ex.rd;
      m_sh_rw = m_ex.rw;
      m_ill = !m_sq && d.bad;
      m_sq = (ps != 2'd0);
      m_ex = nx;
    end
    #1;
    chk("id_ex", 128'({ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_alu_op,
                       ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write}), 128'(m_ex));
    chk("illegal", 128'(illegal), 128'(m_ill));
  endtask

  initial begin
    logic s;
    logic held;
    logic r;
    logic [31:0] ins;
    //          r  ins           pcn           we wrd wd            ps stl ak addr          v  rs rsd           ill
    tbl[0]  = '{1'b0, 32'h10210003, 32'h00000104, 1'b0, 5'd0, 32'h0,     2'd0, 1'b0, 2'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0};
    tbl[1]  = '{1'b0, 32'h10210003, 32'h00000104, 1'b0, 5'd0, 32'h0,     2'd0, 1'b0, 2'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0};
    tbl[2]  = '{1'b1, 32'h00221820, 32'h00000100, 1'b1, 5'd1, 32'h5,     2'd0, 1'b0, 2'd0, 32'h0,        1'b1, 5'd1, 32'h5,    1'b0};
    tbl[3]  = '{1'b1, 32'h00011820, 32'h00000100, 1'b1, 5'd0, 32'hFF,    2'd0, 1'b0, 2'd0, 32'h0,        1'b1, 5'd0, 32'h0,    1'b0};
    tbl[4]  = '{1'b1, 32'h8C220000, 32'h00000100, 1'b0, 5'd0, 32'h0,     2'd0, 1'b0, 2'd0, 32'h0,        1'b1, 5'd1, 32'h5,    1'b0};
    tbl[5]  = '{1'b1, 32'h00432020, 32'h00000104, 1'b0, 5'd0, 32'h0,     2'd0, 1'b1, 2'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0};
    tbl[6]  = '{1'b1, 32'h00432020, 32'h00000104, 1'b1, 5'd2, 32'h1234,  2'd0, 1'b0, 2'd0, 32'h0,        1'b1, 5'd2, 32'h1234, 1'b0};
    tbl[7]  = '{1'b1, 32'h10210003, 32'h00000104, 1'b0, 5'd0, 32'h0,     2'd2, 1'b0, 2'd1, 32'h00000110, 1'b1, 5'd1, 32'h5,    1'b0};
    tbl[8]  = '{1'b1, 32'h20420001, 32'h00000108, 1'b0, 5'd0, 32'h0,     2'd0, 1'b0, 2'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0};
    tbl[9]  = '{1'b1, 32'h08000040, 32'h80000008, 1'b0, 5'd0, 32'h0,     2'd1, 1'b0, 2'd2, 32'h80000100, 1'b1, 5'd0, 32'h0,    1'b0};
    tbl[10] = '{1'b1, 32'h08000040, 32'h8000000C, 1'b0, 5'd0, 32'h0,     2'd0, 1'b0, 2'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0};
    tbl[11] = '{1'b1, 32'h20050007, 32'h000001F8, 1'b0, 5'd0, 32'h0,     2'd0, 1'b0, 2'd0, 32'h0,        1'b1, 5'd0, 32'h0,    1'b0};
    tbl[12] = '{1'b1, 32'h14A0FFFF, 32'h00000200, 1'b0, 5'd0, 32'h0,     2'd0, 1'b1, 2'd1, 32'h000001FC, 1'b0, 5'd0, 32'h0,    1'b0};
    tbl[13] = '{1'b1, 32'h14A0FFFF, 32'h00000200, 1'b0, 5'd0, 32'h0,     2'd0, 1'b1, 2'd1, 32'h000001FC, 1'b0, 5'd0, 32'h0,    1'b0};
    tbl[14] = '{1'b1, 32'h14A0FFFF, 32'h00000200, 1'b1, 5'd5, 32'h7,     2'd2, 1'b0, 2'd1, 32'h000001FC, 1'b1, 5'd5, 32'h7,    1'b0};
    tbl[15] = '{1'b1, 32'h00000000, 32'h00000204, 1'b0, 5'd0, 32'h0,     2'd0, 1'b0, 2'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0};
    tbl[16] = '{1'b1, 32'hFC000000, 32'h00000100, 1'b0, 5'd0, 32'h0,     2'd0, 1'b0, 2'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1};
    tbl[17] = '{1'b1, 32'h00000000, 32'h00000104, 1'b0, 5'd0, 32'h0,     2'd0, 1'b0, 2'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0};
    tbl[18] = '{1'b1, 32'h8C220000, 32'h00000100, 1'b0, 5'd0, 32'h0,     2'd0, 1'b0, 2'd0, 32'h0,        1'b1, 5'd1, 32'h5,    1'b0};
    tbl[19] = '{1'b1, 32'h00432020, 32'h00000104, 1'b0, 5'd0, 32'h0,     2'd0, 1'b1, 2'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0};
    tbl[20] = '{1'b0, 32'h00432020, 32'h00000104, 1'b0, 5'd0, 32'h0,     2'd0, 1'b0, 2'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0};
    tbl[21] = '{1'b1, 32'h00432020, 32'h00000104, 1'b0, 5'd0, 32'h0,     2'd0, 1'b0, 2'd0, 32'h0,        1'b1, 5'd2, 32'h0,    1'b0};
    tbl[22] = '{1'b1, 32'h00221820, 32'h00000108, 1'b0, 5'd0, 32'h0,     2'd0, 1'b0, 2'd0, 32'h0,        1'b1, 5'd1, 32'h0,    1'b0};

    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_ex = '0; m_sh_rd = 5'd0; m_sh_rw = 1'b0; m_sq = 1'b0; m_ill = 1'b0;
    rst = 1'b0; Instruction = 32'd0; PC_Next = 32'd0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 23; i++) begin
      step(tbl[i].r, tbl[i].ins, tbl[i].pcn, tbl[i].we, tbl[i].wrd, tbl[i].wd, s);
      chk($sformatf("row%0d pc_src", i), 128'(a_pcsrc), 128'(tbl[i].ps));
      chk($sformatf("row%0d stall", i), 128'(a_stall), 128'(tbl[i].stl));
      if (tbl[i].ak == 2'd1) chk($sformatf("row%0d branch_addr", i), 128'(a_baddr), 128'(tbl[i].addr));
      if (tbl[i].ak == 2'd2) chk($sformatf("row%0d jump_addr", i), 128'(a_jaddr), 128'(tbl[i].addr));
      chk($sformatf("row%0d ex_valid", i), 128'(ex_valid), 128'(tbl[i].v));
      chk($sformatf("row%0d ex_rs", i), 128'(ex_rs), 128'(tbl[i].rs));
      chk($sformatf("row%0d ex_rs_data", i), 128'(ex_rs_data), 128'(tbl[i].rsd));
      chk($sformatf("row%0d illegal", i), 128'(illegal), 128'(tbl[i].ill));
      $display("row %0d: rst=%0b ins=%h pc_src=%0d stall=%0b ex_valid=%0b ex_rs=%0d ex_rs_data=%h illegal=%0b",
               i, tbl[i].r, tbl[i].ins, a_pcsrc, a_stall, ex_valid, ex_rs, ex_rs_data, illegal);
    end

    // Random streams; a stalled word is held, as fetch would.
    held = 1'b0;
    ins = 32'd0;
    for (int n = 0; n < 2500; n++) begin
      if (!held) ins = rand_instr();
      r = ($urandom_range(0, 49) != 0);
      step(r, ins, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, s);
      held = s;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
